// File: rtl/mips_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_model
// Description : Instruction/data memory model for the single-cycle mips core.
//               After reset both memories are swept to zero (CLEAR). A program
//               is then written through a valid/ready port (LOAD). A start
//               pulse releases the core (RUN). In RUN, instr is served from pc
//               and readdata from aluout. Each store is written to dmem and
//               logged into a capture FIFO. RUN cycles are counted. The core
//               is stopped on a halt word (HALT) or an address fault (FAULT).
//
// Ports       : clk, reset (sync, active-low)
//               start                       - LOAD->RUN, HALT/FAULT->LOAD
//               load_valid/load_ready/load_addr/load_data - program load port
//               cpu_reset                   - core reset, high outside RUN
//               pc -> instr                 - instruction fetch
//               memwrite/aluout/writedata -> readdata - data port
//               log_valid/log_ready/log_addr/log_data/log_overflow - store log
//               state, cycles               - status
//
// Option      : MIPS_MEM_ALIGN_CHECK_EN - misaligned pc or store address
//               faults the run (when undefined, the low address bits are
//               ignored)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_model #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          DMEM_DEPTH = 64,
    parameter int          LOG_DEPTH  = 8,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    output logic                          cpu_reset,
    input  logic [31:0]                   pc,
    output logic [31:0]                   instr,
    input  logic                          memwrite,
    input  logic [31:0]                   aluout,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          log_valid,
    input  logic                          log_ready,
    output logic [31:0]                   log_addr,
    output logic [31:0]                   log_data,
    output logic                          log_overflow,
    output logic [2:0]                    state,
    output logic [31:0]                   cycles
);

    localparam int AW        = $clog2(IMEM_DEPTH);
    localparam int DW        = $clog2(DMEM_DEPTH);
    localparam int LW        = $clog2(LOG_DEPTH);
    localparam int MAX_DEPTH = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
    localparam int CW        = $clog2(MAX_DEPTH);

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [31:0] C_BAD_READ = 32'hDEAD_BEEF;

    logic [31:0] r_imem [IMEM_DEPTH];
    logic [31:0] r_dmem [DMEM_DEPTH];
    logic [31:0] r_log_a [LOG_DEPTH];
    logic [31:0] r_log_d [LOG_DEPTH];

    logic [2:0]  r_state, w_state_nxt;
    logic [CW-1:0] r_idx;
    logic [31:0] r_cycles;
    logic [LW:0] r_wptr, r_rptr;
    logic        r_ovf;

    logic w_run, w_pc_oor, w_alu_oor, w_pc_mis, w_alu_mis;
    logic w_fault, w_halt, w_store, w_load_fire;
    logic w_full, w_empty, w_pop, w_push_ok;
    logic w_idx_imem, w_idx_dmem;
    logic [31:0] w_instr;
    logic w_unused;

    assign w_run     = (r_state == ST_RUN);
    assign w_pc_oor  = (pc[31:2] >= 30'(IMEM_DEPTH));
    assign w_alu_oor = (aluout[31:2] >= 30'(DMEM_DEPTH));

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    assign w_pc_mis  = (pc[1:0] != 2'b00);
    assign w_alu_mis = (aluout[1:0] != 2'b00);
`else
    assign w_pc_mis  = 1'b0;
    assign w_alu_mis = 1'b0;
`endif
    // Low address bits only matter when the alignment check is built in.
    assign w_unused = ^{pc[1:0], aluout[1:0]};

    assign w_instr  = (w_run && !w_pc_oor) ? r_imem[pc[AW+1:2]] : 32'h0;
    assign readdata = w_alu_oor ? C_BAD_READ : r_dmem[aluout[DW+1:2]];

    // Fault takes priority over halt; a faulting or halting fetch performs
    // no store, since that instruction is never executed by the core.
    assign w_fault = w_run && (w_pc_oor || w_pc_mis ||
                               (memwrite && (w_alu_oor || w_alu_mis)));
    assign w_halt  = w_run && (w_instr == HALT_INSTR);
    assign w_store = w_run && memwrite && !w_fault && !w_halt && reset;

    assign w_load_fire = (r_state == ST_LOAD) && load_valid && reset;

    assign w_idx_imem = (32'(r_idx) < 32'(IMEM_DEPTH));
    assign w_idx_dmem = (32'(r_idx) < 32'(DMEM_DEPTH));

    // Store-log FIFO with an extra wrap bit on each pointer.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[LW] != r_rptr[LW]) &&
                       (r_wptr[LW-1:0] == r_rptr[LW-1:0]);
    assign w_pop     = log_ready && !w_empty;
    assign w_push_ok = w_store && (!w_full || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_idx == CW'(MAX_DEPTH - 1)) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (start)                       w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_fault)     w_state_nxt = ST_FAULT;
                else if (w_halt) w_state_nxt = ST_HALT;
            end
            ST_HALT, ST_FAULT: if (start)              w_state_nxt = ST_LOAD;
            default:                                   w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_CLEAR;
            r_idx    <= '0;
            r_cycles <= 32'h0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) r_idx <= r_idx + 1'b1;

            if (w_run) begin
                if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'h1;
            end else if ((r_state == ST_HALT || r_state == ST_FAULT) && start) begin
                r_cycles <= 32'h0;
            end

            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (w_store && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Storage arrays carry no reset; the CLEAR sweep zeroes them instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (r_state == ST_CLEAR) begin
                if (w_idx_imem) r_imem[r_idx[AW-1:0]] <= 32'h0;
                if (w_idx_dmem) r_dmem[r_idx[DW-1:0]] <= 32'h0;
            end else if (w_load_fire) begin
                r_imem[load_addr] <= load_data;
            end
            if (w_store) r_dmem[aluout[DW+1:2]] <= writedata;
            if (w_push_ok) begin
                r_log_a[r_wptr[LW-1:0]] <= aluout;
                r_log_d[r_wptr[LW-1:0]] <= writedata;
            end
        end
    end

    assign instr        = w_instr;
    assign state        = r_state;
    assign cycles       = r_cycles;
    assign cpu_reset    = !w_run;
    assign load_ready   = (r_state == ST_LOAD);
    assign log_valid    = !w_empty;
    assign log_addr     = r_log_a[r_rptr[LW-1:0]];
    assign log_data     = r_log_d[r_rptr[LW-1:0]];
    assign log_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mem_model
// Description : Directed bench for mips_mem_model. The bench plays the part
//               of the core by driving pc/memwrite/aluout/writedata directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem_model;

    logic        clk = 1'b0;
    logic        reset, start, load_valid, memwrite, log_ready;
    logic [5:0]  load_addr;
    logic [31:0] load_data, pc, aluout, writedata;
    logic        load_ready, cpu_reset, log_valid, log_overflow;
    logic [31:0] instr, readdata, log_addr, log_data, cycles;
    logic [2:0]  state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mips_mem_model dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .cpu_reset(cpu_reset), .pc(pc), .instr(instr),
        .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .readdata(readdata), .log_valid(log_valid), .log_ready(log_ready),
        .log_addr(log_addr), .log_data(log_data),
        .log_overflow(log_overflow), .state(state), .cycles(cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [5:0] a, input logic [31:0] d);
        load_valid = 1'b1; load_addr = a; load_data = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (state == 3'd0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; load_valid = 1'b0; memwrite = 1'b0;
        log_ready = 1'b0; load_addr = '0; load_data = '0;
        pc = '0; aluout = '0; writedata = '0;
        tick(); tick();

        // Reset state
        chk("rst_state",    32'(state), 32'd0);
        chk("rst_cpu_rst",  32'(cpu_reset), 32'd1);
        chk("rst_ld_rdy",   32'(load_ready), 32'd0);
        chk("rst_log_vld",  32'(log_valid), 32'd0);
        chk("rst_ovf",      32'(log_overflow), 32'd0);
        chk("rst_cycles",   cycles, 32'd0);
        chk("rst_instr",    instr, 32'd0);

        // CLEAR sweep length and wiped memory
        reset = 1'b1;
        wait_clear("clear_len");
        chk("load_state", 32'(state), 32'd1);
        chk("load_rdy",   32'(load_ready), 32'd1);
        aluout = 32'h0;  #1; chk("dmem0_zero",  readdata, 32'h0);
        aluout = 32'hFC; #1; chk("dmem63_zero", readdata, 32'h0);
        aluout = 32'h100; #1; chk("dmem_oor_rd", readdata, 32'hDEAD_BEEF);
        chk("load_instr0", instr, 32'h0);
        aluout = 32'h0;

        // Program load; last word accepted together with start
        load_word(6'd0, 32'h2002_0005);
        load_word(6'd1, 32'h2003_000C);
        load_word(6'd2, 32'h2067_FFF7);
        chk("load_cpu_rst", 32'(cpu_reset), 32'd1);
        load_valid = 1'b1; load_addr = 6'd3; load_data = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        chk("run_state",   32'(state), 32'd2);
        chk("run_cpu_rst", 32'(cpu_reset), 32'd0);
        pc = 32'd0;  #1; chk("fetch0", instr, 32'h2002_0005); tick();
        pc = 32'd4;  #1; chk("fetch1", instr, 32'h2003_000C); tick();
        pc = 32'd8;  #1; chk("fetch2", instr, 32'h2067_FFF7); tick();
        pc = 32'd12; #1; chk("fetch3", instr, 32'hFFFF_FFFF);
        pc = 32'd16; #1; chk("fetch4_zero", instr, 32'h0);
        pc = 32'd12; tick();
        chk("halt_state",   32'(state), 32'd3);
        chk("halt_cycles",  cycles, 32'd4);
        chk("halt_cpu_rst", 32'(cpu_reset), 32'd1);
        chk("halt_instr",   instr, 32'h0);

        // Store then load back through the log
        do_start();
        chk("reload_state",  32'(state), 32'd1);
        chk("reload_cycles", cycles, 32'd0);
        load_word(6'd0, 32'hAC04_0010);
        load_word(6'd1, 32'h8C05_0010);
        load_word(6'd2, 32'hFFFF_FFFF);
        do_start();
        pc = 32'd0; memwrite = 1'b1; aluout = 32'h10; writedata = 32'h1234_4321;
        tick();
        memwrite = 1'b0;
        chk("sw_log_vld",  32'(log_valid), 32'd1);
        chk("sw_log_addr", log_addr, 32'h10);
        chk("sw_log_data", log_data, 32'h1234_4321);
        pc = 32'd4; #1; chk("lw_readdata", readdata, 32'h1234_4321);
        log_ready = 1'b1; tick(); log_ready = 1'b0;
        chk("sw_log_empty", 32'(log_valid), 32'd0);
        pc = 32'd8; tick();
        chk("sw_halt", 32'(state), 32'd3);

        // Log overflow: 8 fill, 1 pop+push when full, 1 dropped
        do_start(); do_start();
        pc = 32'd0;
        for (int i = 0; i < 8; i++) begin
            memwrite = 1'b1; aluout = 32'h20 + 32'(4 * i); writedata = 32'hA000_0000 + 32'(i);
            tick();
        end
        memwrite = 1'b0;
        chk("full_no_ovf", 32'(log_overflow), 32'd0);
        memwrite = 1'b1; aluout = 32'h40; writedata = 32'hA000_0008; log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        chk("poppush_no_ovf", 32'(log_overflow), 32'd0);
        aluout = 32'h44; writedata = 32'hA000_0009;
        tick();
        memwrite = 1'b0;
        chk("drop_ovf", 32'(log_overflow), 32'd1);
        for (int j = 1; j <= 8; j++) begin
            chk("ovf_log_addr", log_addr, 32'h20 + 32'(4 * j));
            chk("ovf_log_data", log_data, 32'hA000_0000 + 32'(j));
            log_ready = 1'b1; tick(); log_ready = 1'b0;
        end
        chk("ovf_log_drained", 32'(log_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            aluout = 32'h20 + 32'(4 * i); #1;
            chk("ovf_dmem", readdata, 32'hA000_0000 + 32'(i));
        end

        // pc fault
        pc = 32'h100; aluout = 32'h0; #1;
        chk("pc_oor_instr", instr, 32'h0);
        tick();
        chk("pc_fault_state", 32'(state), 32'd4);
        chk("pc_fault_cpu_rst", 32'(cpu_reset), 32'd1);

        // Store fault
        do_start(); do_start();
        pc = 32'd0; memwrite = 1'b1; aluout = 32'h400; writedata = 32'h1;
        tick();
        memwrite = 1'b0;
        chk("st_fault_state", 32'(state), 32'd4);
        chk("st_fault_nolog", 32'(log_valid), 32'd0);

        // Reset mid-RUN
        do_start(); do_start();
        pc = 32'd0; memwrite = 1'b1; aluout = 32'h10; writedata = 32'h77;
        tick();
        memwrite = 1'b0;
        tick();
        chk("pre_rst_log", 32'(log_valid), 32'd1);
        reset = 1'b0; tick();
        chk("mid_rst_state",  32'(state), 32'd0);
        chk("mid_rst_log",    32'(log_valid), 32'd0);
        chk("mid_rst_cycles", cycles, 32'd0);
        chk("mid_rst_ovf",    32'(log_overflow), 32'd0);
        chk("mid_rst_cpu",    32'(cpu_reset), 32'd1);
        reset = 1'b1;
        wait_clear("reclear_len");
        aluout = 32'h10; #1; chk("reclear_dmem4", readdata, 32'h0);

        // Misaligned store
        do_start();
        pc = 32'd0; memwrite = 1'b1; aluout = 32'h11; writedata = 32'h5555_AAAA;
        tick();
        memwrite = 1'b0; aluout = 32'h10; #1;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        chk("mis_state",    32'(state), 32'd4);
        chk("mis_readdata", readdata, 32'h0);
        chk("mis_log",      32'(log_valid), 32'd0);
`else
        chk("mis_state",    32'(state), 32'd2);
        chk("mis_readdata", readdata, 32'h5555_AAAA);
        chk("mis_log",      32'(log_valid), 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
